// File: rtl/conv33_window_sched_if.sv
// Handshake and status bundle between the 3x3 window scheduler, the
// sliding-window generator and the conv33 input stage.
interface conv33_window_sched_if #(
    parameter int COORD_W = 8,
    parameter int CNT_W   = 16
);
    logic               start;
    logic               busy;
    logic               done;
    logic               win_valid_in;
    logic               win_ready_out;
    logic               conv_start;
    logic               conv_valid;
    logic               conv_ready;
    logic               conv_done;
    logic [COORD_W-1:0] win_col;
    logic [COORD_W-1:0] win_row;
    logic [COORD_W-1:0] ch_idx;
    logic               first_ch;
    logic               last_win;
    logic [CNT_W-1:0]   win_cnt;

    // Scheduler side: consumes requests and handshakes, drives status and tags.
    modport master (
        input  start, win_valid_in, conv_ready, conv_done,
        output busy, done, win_ready_out, conv_start, conv_valid,
               win_col, win_row, ch_idx, first_ch, last_win, win_cnt
    );

    // Environment side: window generator, input stage and frame controller.
    modport slave (
        output start, win_valid_in, conv_ready, conv_done,
        input  busy, done, win_ready_out, conv_start, conv_valid,
               win_col, win_row, ch_idx, first_ch, last_win, win_cnt
    );
endinterface

// File: rtl/conv33_window_sched.sv
// Frame-level sequencer for the conv33 input stage: launches the stage,
// gates the window stream into it, tags every window with its column, row
// and channel, then waits for the stage to finish before reporting done.
module conv33_window_sched #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int IN_CH   = 1,
    parameter int COORD_W = 8,
    parameter int CNT_W   = 16
) (
    input logic                   clk,
    input logic                   rst,
    conv33_window_sched_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - 3);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_H - 3);
    localparam logic [COORD_W-1:0] CH_LAST  = COORD_W'(IN_CH - 1);

    state_t             state;
    state_t             state_next;
    logic [COORD_W-1:0] col_q;
    logic [COORD_W-1:0] row_q;
    logic [COORD_W-1:0] ch_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               transfer;
    logic               at_last;
    logic               launch_req;

    assign transfer   = (state == RUN) && bus.win_valid_in && bus.conv_ready;
    assign at_last    = (col_q == COL_LAST) && (row_q == ROW_LAST) && (ch_q == CH_LAST);
    assign launch_req = (state == IDLE) && bus.start;

    // State register; reset drops straight back to IDLE without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus Moore outputs; the window handshake is only
    // passed through while running so nothing slips in during launch or drain.
    always_comb begin
        state_next         = state;
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.conv_start     = 1'b0;
        bus.conv_valid     = 1'b0;
        bus.win_ready_out  = 1'b0;
        bus.win_col        = col_q;
        bus.win_row        = row_q;
        bus.ch_idx         = ch_q;
        bus.win_cnt        = cnt_q;
        bus.first_ch       = (state != IDLE) && (ch_q == '0);
        bus.last_win       = (state != IDLE) && at_last;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                bus.busy       = 1'b1;
                bus.conv_start = 1'b1;
                state_next     = RUN;
            end
            RUN: begin
                bus.busy          = 1'b1;
                bus.conv_valid    = bus.win_valid_in;
                bus.win_ready_out = bus.conv_ready;
                if (transfer && at_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (bus.conv_done) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Window position and count; indices freeze on the final window so the
    // tags still describe it while the input stage drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            ch_q  <= '0;
            cnt_q <= '0;
        end else if (launch_req) begin
            col_q <= '0;
            row_q <= '0;
            ch_q  <= '0;
            cnt_q <= '0;
        end else if (transfer) begin
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (!at_last) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    if (row_q == ROW_LAST) begin
                        row_q <= '0;
                        ch_q  <= ch_q + COORD_W'(1);
                    end else begin
                        row_q <= row_q + COORD_W'(1);
                    end
                end else begin
                    col_q <= col_q + COORD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv33_window_sched.sv
// Bench for conv33_window_sched: two 5x5 instances (one and two input
// channels) share the stimulus; a reference model with a window scoreboard
// predicts every output cycle by cycle.
module tb_conv33_window_sched;

    localparam int S_IDLE   = 0;
    localparam int S_LAUNCH = 1;
    localparam int S_RUN    = 2;
    localparam int S_DRAIN  = 3;
    localparam int S_FINISH = 4;
    localparam int FRAME_LIMIT = 400;

    typedef struct {
        int row;
        int col;
        int ch;
        bit first;
        bit last;
    } win_t;

    typedef struct {
        logic       busy;
        logic       done;
        logic       conv_start;
        logic       conv_valid;
        logic       win_ready_out;
        logic       first_ch;
        logic       last_win;
        logic [7:0] win_col;
        logic [7:0] win_row;
        logic [7:0] ch_idx;
        logic [15:0] win_cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    bit start_req   = 1'b0;
    bit start_v     = 1'b0;
    bit win_valid_v = 1'b0;
    bit conv_ready_v = 1'b0;
    bit bp_mode     = 1'b0;
    bit proto_mode  = 1'b0;
    int drain_dly   = 2;
    bit cd [2];

    int m_state [2];
    int m_cnt   [2];
    int xfers   [2];
    int drain_t [2];
    int obs_done [2];
    win_t sbq0 [$];
    win_t sbq1 [$];

    conv33_window_sched_if #(.COORD_W(8), .CNT_W(16)) if0 ();
    conv33_window_sched_if #(.COORD_W(8), .CNT_W(16)) if1 ();

    conv33_window_sched #(.IMG_W(5), .IMG_H(5), .IN_CH(1), .COORD_W(8), .CNT_W(16)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.master)
    );

    conv33_window_sched #(.IMG_W(5), .IMG_H(5), .IN_CH(2), .COORD_W(8), .CNT_W(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.master)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic int nch(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s inst%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic get_obs(input int k, output obs_t o);
        if (k == 0) begin
            o.busy = if0.busy; o.done = if0.done; o.conv_start = if0.conv_start;
            o.conv_valid = if0.conv_valid; o.win_ready_out = if0.win_ready_out;
            o.first_ch = if0.first_ch; o.last_win = if0.last_win;
            o.win_col = if0.win_col; o.win_row = if0.win_row; o.ch_idx = if0.ch_idx;
            o.win_cnt = if0.win_cnt;
        end else begin
            o.busy = if1.busy; o.done = if1.done; o.conv_start = if1.conv_start;
            o.conv_valid = if1.conv_valid; o.win_ready_out = if1.win_ready_out;
            o.first_ch = if1.first_ch; o.last_win = if1.last_win;
            o.win_col = if1.win_col; o.win_row = if1.win_row; o.ch_idx = if1.ch_idx;
            o.win_cnt = if1.win_cnt;
        end
    endtask

    task automatic load_sb(input int k);
        win_t w;
        if (k == 0) sbq0.delete(); else sbq1.delete();
        for (int ch = 0; ch < nch(k); ch++) begin
            for (int row = 0; row < 3; row++) begin
                for (int col = 0; col < 3; col++) begin
                    w.row = row; w.col = col; w.ch = ch;
                    w.first = (ch == 0);
                    w.last = (row == 2) && (col == 2) && (ch == nch(k) - 1);
                    if (k == 0) sbq0.push_back(w); else sbq1.push_back(w);
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = S_IDLE;
            m_cnt[k] = 0;
            xfers[k] = 0;
            drain_t[k] = 0;
        end
        sbq0.delete();
        sbq1.delete();
    endtask

    task automatic check_zero(input int k);
        obs_t o;
        get_obs(k, o);
        chk("rst_busy", k, o.busy, 0);
        chk("rst_done", k, o.done, 0);
        chk("rst_conv_start", k, o.conv_start, 0);
        chk("rst_conv_valid", k, o.conv_valid, 0);
        chk("rst_win_ready", k, o.win_ready_out, 0);
        chk("rst_first_ch", k, o.first_ch, 0);
        chk("rst_last_win", k, o.last_win, 0);
        chk("rst_win_col", k, o.win_col, 0);
        chk("rst_win_row", k, o.win_row, 0);
        chk("rst_ch_idx", k, o.ch_idx, 0);
        chk("rst_win_cnt", k, o.win_cnt, 0);
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model.
    task automatic cycle();
        obs_t o;
        win_t w;
        int sz;
        bit xfer;
        bit force_done;
        if (bp_mode) begin
            win_valid_v  = 1'($urandom_range(0, 1));
            conv_ready_v = ~conv_ready_v;
        end else begin
            win_valid_v  = 1'b1;
            conv_ready_v = 1'b1;
        end
        start_v = start_req || (proto_mode && ((m_state[0] == S_RUN && xfers[0] == 3) ||
                  m_state[0] == S_DRAIN || m_state[0] == S_FINISH));
        force_done = proto_mode && m_state[0] == S_RUN && xfers[0] == 5;
        for (int k = 0; k < 2; k++) begin
            cd[k] = force_done || (m_state[k] == S_DRAIN && drain_t[k] == 0);
        end
        if0.start = start_v; if1.start = start_v;
        if0.win_valid_in = win_valid_v; if1.win_valid_in = win_valid_v;
        if0.conv_ready = conv_ready_v; if1.conv_ready = conv_ready_v;
        if0.conv_done = cd[0]; if1.conv_done = cd[1];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            get_obs(k, o);
            if (o.done === 1'b1) obs_done[k]++;
            chk("busy", k, o.busy, (m_state[k] >= S_LAUNCH && m_state[k] <= S_DRAIN));
            chk("done", k, o.done, (m_state[k] == S_FINISH));
            chk("conv_start", k, o.conv_start, (m_state[k] == S_LAUNCH));
            chk("conv_valid", k, o.conv_valid, (m_state[k] == S_RUN && win_valid_v));
            chk("win_ready_out", k, o.win_ready_out, (m_state[k] == S_RUN && conv_ready_v));
            xfer = (m_state[k] == S_RUN) && win_valid_v && conv_ready_v;
            sz = (k == 0) ? sbq0.size() : sbq1.size();
            case (m_state[k])
                S_IDLE: begin
                    chk("idle_first_ch", k, o.first_ch, 0);
                    chk("idle_win_cnt", k, o.win_cnt, m_cnt[k]);
                    if (start_v) begin
                        m_state[k] = S_LAUNCH;
                        m_cnt[k] = 0;
                        xfers[k] = 0;
                        load_sb(k);
                    end
                end
                S_LAUNCH: begin
                    chk("launch_win_cnt", k, o.win_cnt, 0);
                    m_state[k] = S_RUN;
                end
                S_RUN: begin
                    if (sz == 0) begin
                        chk("sb_underflow", k, sz, 1);
                    end else begin
                        w = (k == 0) ? sbq0[0] : sbq1[0];
                        chk("win_row", k, o.win_row, w.row);
                        chk("win_col", k, o.win_col, w.col);
                        chk("ch_idx", k, o.ch_idx, w.ch);
                        chk("first_ch", k, o.first_ch, w.first);
                        chk("last_win", k, o.last_win, w.last);
                        chk("win_cnt", k, o.win_cnt, m_cnt[k]);
                        if (xfer) begin
                            if (k == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
                            m_cnt[k]++;
                            xfers[k]++;
                            if (w.last) begin
                                m_state[k] = S_DRAIN;
                                drain_t[k] = drain_dly;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    chk("drain_last_win", k, o.last_win, 1);
                    chk("drain_win_cnt", k, o.win_cnt, m_cnt[k]);
                    if (cd[k]) m_state[k] = S_FINISH;
                    else if (drain_t[k] > 0) drain_t[k]--;
                end
                default: begin
                    chk("finish_win_cnt", k, o.win_cnt, m_cnt[k]);
                    m_state[k] = S_IDLE;
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    // Starts both instances and runs until both models return to IDLE.
    task automatic run_frame(input string name);
        int n;
        int d0;
        int d1;
        d0 = obs_done[0];
        d1 = obs_done[1];
        start_req = 1'b1;
        cycle();
        start_req = 1'b0;
        n = 0;
        while ((m_state[0] != S_IDLE || m_state[1] != S_IDLE) && n < FRAME_LIMIT) begin
            cycle();
            n++;
        end
        chk({name, "_in_time"}, 0, (n < FRAME_LIMIT), 1);
        chk({name, "_transfers"}, 0, xfers[0], 9);
        chk({name, "_transfers"}, 1, xfers[1], 18);
        chk({name, "_done_pulses"}, 0, obs_done[0] - d0, 1);
        chk({name, "_done_pulses"}, 1, obs_done[1] - d1, 1);
    endtask

    // Directed sequence: reset, streaming, backpressure, protocol abuse, mid-frame reset.
    initial begin
        int n;
        obs_done[0] = 0;
        obs_done[1] = 0;
        model_reset();
        if0.start = 0; if1.start = 0;
        if0.win_valid_in = 0; if1.win_valid_in = 0;
        if0.conv_ready = 0; if1.conv_ready = 0;
        if0.conv_done = 0; if1.conv_done = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero(0);
        check_zero(1);
        rst = 1'b0;
        cycle();

        $display("[TB] streaming frame");
        run_frame("stream");
        repeat (2) cycle();

        $display("[TB] backpressure frame");
        bp_mode = 1'b1;
        run_frame("backpressure");
        bp_mode = 1'b0;
        repeat (2) cycle();

        $display("[TB] protocol frame");
        proto_mode = 1'b1;
        drain_dly = 5;
        run_frame("protocol");
        proto_mode = 1'b0;
        drain_dly = 2;
        repeat (2) cycle();

        $display("[TB] mid-frame reset");
        start_req = 1'b1;
        cycle();
        start_req = 1'b0;
        n = 0;
        while (xfers[0] < 4 && n < FRAME_LIMIT) begin
            cycle();
            n++;
        end
        chk("pre_reset_xfers", 0, xfers[0], 4);
        rst = 1'b1;
        #1;
        check_zero(0);
        check_zero(1);
        model_reset();
        repeat (3) cycle();
        rst = 1'b0;
        repeat (2) cycle();
        run_frame("after_reset");
        repeat (2) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv33_window_sched.md
Name: conv33_window_sched

Overview:
Frame-level sequencer for the 3x3 convolution input stage. On a frame start it pulses the input stage's start and gates the sliding-window stream into it. It counts accepted windows over columns, rows and input channels, and tags each window with its position. It waits for the input stage's done, then reports frame completion. It sits between the sliding-window generator and the conv33 input stage/buffer.

Parameters:
IMG_W, 28, input feature-map width in pixels (>=3)
IMG_H, 28, input feature-map height in pixels (>=3)
IN_CH, 1, input channels processed sequentially per frame (>=1)
COORD_W, 8, width of row/col/channel index outputs; must hold max(IMG_W, IMG_H, IN_CH)
CNT_W, 16, width of accepted-window counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  frame start request; sampled in IDLE only
busy  out  1  high from the cycle after start is accepted until done pulses
done  out  1  one-cycle pulse when the frame has completed
win_valid_in  in  1  window generator has a 3x3 window
win_ready_out  out  1  scheduler/input stage accepts the window
conv_start  out  1  one-cycle start pulse to the input stage
conv_valid  out  1  window valid to the input stage
conv_ready  in  1  input stage ready
conv_done  in  1  input stage completion
win_col  out  COORD_W  column index of the current window (0..IMG_W-3)
win_row  out  COORD_W  row index of the current window (0..IMG_H-3)
ch_idx  out  COORD_W  current input channel (0..IN_CH-1)
first_ch  out  1  ch_idx==0 (downstream clears its accumulator)
last_win  out  1  current window is the final window of the final channel
win_cnt  out  CNT_W  accepted windows since start; saturates at all-ones

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs are 0 and all counters are 0. first_ch=0 while in IDLE.
- FSM states: IDLE, LAUNCH, RUN, DRAIN, FINISH.
- IDLE: start=1 -> LAUNCH. Counters clear and win_cnt=0 on this transition.
- LAUNCH: conv_start=1 for exactly this one cycle; busy=1. Next state is RUN unconditionally.
- RUN: conv_valid = win_valid_in; win_ready_out = conv_ready. Both are 0 in every other state.
- Transfer: a transfer occurs when win_valid_in & conv_ready in RUN. Counters advance only on a transfer.
- Counter update on each transfer:
  - win_col increments.
  - At IMG_W-3, win_col wraps to 0 and win_row increments.
  - At IMG_H-3, win_row wraps to 0 and ch_idx increments.
  - win_cnt increments.
- Index outputs are registered and describe the window presented in the current cycle.
- last_win = (win_col==IMG_W-3)&(win_row==IMG_H-3)&(ch_idx==IN_CH-1), combinational from the counters.
- Transfer with last_win=1 -> DRAIN. Counters then hold their final values.
- DRAIN: no further windows are accepted. Wait for conv_done=1, then go to FINISH.
- conv_done seen in RUN before the last window is ignored.
- FINISH: done=1 for exactly one cycle and busy=0. Then go to IDLE.
- Total transfers per frame = (IMG_W-2)*(IMG_H-2)*IN_CH exactly.
- start while not IDLE: ignored, with no effect on counters or state.
- start in the FINISH cycle: ignored. It must be reasserted in IDLE.
- win_valid_in with conv_ready=0: no transfer and no counter change. The window generator holds its data (standard valid/ready; the scheduler never drops a window).
- rst asserted mid-frame: immediate return to IDLE with all outputs 0. No done pulse is produced.
- Latency: start (IDLE) to conv_start is 1 cycle. The first possible transfer is 2 cycles after start. Final transfer to done is (conv_done arrival) + 1 cycle.

Test Plan:
- IMG_W=5, IMG_H=5, IN_CH=1; start, win_valid_in=1, conv_ready=1 continuously; conv_done 3 cycles after the last transfer:
  - exactly 9 transfers; (row,col) steps (0,0),(0,1),(0,2),(1,0)...(2,2);
  - last_win only on (2,2); win_cnt=9;
  - done pulses once, 1 cycle after conv_done.
- IMG_W=5, IMG_H=5, IN_CH=2:
  - 18 transfers; ch_idx goes 0->1 after transfer 9;
  - first_ch=1 for transfers 1-9 and 0 for 10-18;
  - last_win only on transfer 18.
- Backpressure: conv_ready toggles 1/0 every cycle and win_valid_in is random:
  - win_ready_out mirrors conv_ready in RUN;
  - counters advance only when valid&ready;
  - the total is still 9 for the 5x5 case.
- Protocol: pulse start again during RUN and during DRAIN:
  - no effect on state or counters;
  - conv_done pulsed mid-RUN is ignored, with no early done.
- Reset: assert rst after 4 transfers:
  - all outputs 0 immediately; no done;
  - a subsequent start runs a full 9-window frame from (0,0) with win_cnt restarting at 0.
